sid_pot_multi: RTL and testbench
================================

# sid_pot_multi

Multi-channel, parametrised paddle/potentiometer digitiser for the SID POTX/POTY path, generalising the single-channel pot sampler. Each channel alternately discharges an external RC node through an open-drain pad, then measures how long the node stays low while charging. It adds saturation, a first-edge measurement mode and power-of-two averaging. Pad buffers stay outside the block: it drives per-channel output-enable bits and receives raw pad inputs, so vendor IO primitives live in the top level.

## Interface
- NUM_CH, 2: number of pot channels, 1..8.
- CNT_W, 8: bits of tick counter and result; each phase lasts 2^CNT_W ticks.
- MODE, 0: 0 = count every charge tick with input low; 1 = count only until the first high.
- AVG_LOG2, 0: number of windows averaged is 2^AVG_LOG2, 0..4.

- clk  in  1  system clock.
- rst  in  1  reset; synchronous to clk, active-high.
- clkEn  in  1  tick enable (SID phi2 rate); all phase and count logic advances only when clkEn=1.
- iPotIn  in  NUM_CH  raw pad inputs, asynchronous.
- oPotOe  out  NUM_CH  pad drive-low enables; 1 = discharge.
- oPotVal  out  NUM_CH*CNT_W  results; channel n occupies bits [n*CNT_W +: CNT_W].
- oValid  out  1  one-clk pulse when oPotVal updates.

## Operation
- Synchroniser: each iPotIn bit passes through 2 flops clocked every clk, ungated by clkEn. All counting uses the synced value s[n].
- Phases: DISCHARGE then CHARGE, shared by all channels. A CNT_W-bit tick counter tcnt increments on clkEn. When tcnt wraps from all-ones to 0, the phase toggles.
- oPotOe: registered, all bits = (phase==DISCHARGE). It is identical for every channel.
- Per-channel count cnt[n] is CNT_W bits wide. It is held at 0 during DISCHARGE.
- During CHARGE on each clkEn tick:
  - MODE 0: cnt += ~s[n].
  - MODE 1: cnt += ~s[n] && !seen[n]. seen[n] is set on the first tick with s[n]=1 and is cleared in DISCHARGE.
- Saturation: cnt stops at 2^CNT_W-1. It never wraps. A full window of lows therefore gives all-ones.
- raw[n] is the count after the final CHARGE tick (tcnt all-ones), including that tick's sample.
- Averaging:
  - Per-channel accumulator is CNT_W+AVG_LOG2 bits.
  - A window counter wcnt is AVG_LOG2 bits.
  - On the final CHARGE tick: if wcnt is not at its maximum, acc += raw. Otherwise oPotVal[n] <= (acc+raw)>>AVG_LOG2 (truncating), acc <= 0, and oValid <= 1.
  - wcnt increments on every final CHARGE tick and wraps.
  - With AVG_LOG2=0, every window updates the output directly.
- Reset values:
  - phase=DISCHARGE, tcnt=0, wcnt=0.
  - cnt, acc, seen = 0.
  - oPotVal=0, oValid=0, oPotOe=all ones; caps are held discharged during reset.
  - Synchroniser flops = 1.

## Timing
- One DISCHARGE+CHARGE window takes 2^(CNT_W+1) clkEn ticks. The output period is 2^(CNT_W+1+AVG_LOG2) ticks.
- After rst deasserts, the first tick is DISCHARGE tick 0. With clkEn=1 continuously and default parameters, oPotOe falls at clk edge 256 and the first oValid is asserted after edge 512.
- oValid and oPotVal change on the same clk edge as the final CHARGE tick. oValid is high for exactly one clk regardless of the clkEn duty cycle.
- Input-to-count latency is 2 clk from the synchroniser. The bench accounts for this when aligning stimulus.
- clkEn=0: all state is frozen except the synchroniser. oValid still drops after one clk.
- rst mid-window returns every register to its reset value on the next edge. Partial counts and accumulators are discarded, and no oValid is produced for that window.
- Simultaneous final tick and rst: rst wins, and oValid stays 0.

## Test plan
- Reset check: during and after rst, oPotOe=all ones, oPotVal=0 and oValid=0. With clkEn=1, oPotOe drops at tick 256, and the first oValid arrives after tick 512. (Defaults: NUM_CH=2, CNT_W=8, MODE=0, AVG_LOG2=0.)
- Static inputs: ch0 synced input held 1 and ch1 held 0 for the whole charge phase. Expected oPotVal ch0=0 and ch1=255 (saturated, not 0).
- Threshold crossing: synced input low for the first 100 charge ticks, then high. Expected oPotVal=100 on both channels, with oValid pulsing once per 512 ticks.
- Mode comparison, glitch pattern: low 10 ticks, high 1, low 20, then high. MODE 0 gives 30; MODE 1 gives 10.
- Averaging: AVG_LOG2=2, with successive windows low for 10, 11, 12, 13 ticks. Expected one oValid after the 4th window with oPotVal=11, and no oValid for windows 1-3.
- clkEn at 1-in-4 duty plus mid-window rst:
  - The same 100-tick pattern still gives 100, with oValid period 2048 clk.
  - Asserting rst at charge tick 50 suppresses that result. The next oValid follows a full 512-tick window.

Source files
------------

// File: rtl/sid_pot_multi.sv
// Multi-channel SID paddle digitiser: a shared discharge/charge window, per-channel
// saturating low-time counters and power-of-two window averaging.
module sid_pot_multi #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8,
  parameter int MODE     = 0,
  parameter int AVG_LOG2 = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clkEn,
  input  logic [NUM_CH-1:0]       iPotIn,
  output logic [NUM_CH-1:0]       oPotOe,
  output logic [NUM_CH*CNT_W-1:0] oPotVal,
  output logic                    oValid
);
  localparam int ACC_W = CNT_W + AVG_LOG2;
  // Keep the window counter at least one bit wide so AVG_LOG2=0 stays legal.
  localparam int WC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [WC_W-1:0]  WC_MAX  = WC_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {DISCHARGE = 1'b0, CHARGE = 1'b1} phase_t;

  phase_t            phase, phase_nxt;
  logic [CNT_W-1:0]  tcnt, tcnt_nxt;
  logic [WC_W-1:0]   wcnt;
  logic              last_tick;
  logic [NUM_CH-1:0] sync_a, sync_b, seen, inc;
  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  cnt_upd [NUM_CH];
  logic [ACC_W-1:0]  acc     [NUM_CH];
  logic [ACC_W-1:0]  sum     [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= {NUM_CH{1'b1}};
      sync_b <= {NUM_CH{1'b1}};
    end else begin
      sync_a <= iPotIn;
      sync_b <= sync_a;
    end
  end

  // Pad enable is registered from the next phase so it flips on the same edge as the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= DISCHARGE;
      tcnt   <= '0;
      oPotOe <= {NUM_CH{1'b1}};
    end else begin
      phase  <= phase_nxt;
      tcnt   <= tcnt_nxt;
      oPotOe <= {NUM_CH{phase_nxt == DISCHARGE}};
    end
  end

  always_comb begin
    phase_nxt = phase;
    tcnt_nxt  = tcnt;
    last_tick = 1'b0;
    if (clkEn) begin
      tcnt_nxt = tcnt + CNT_W'(1);
      if (tcnt == CNT_MAX) begin
        last_tick = (phase == CHARGE);
        case (phase)
          DISCHARGE: phase_nxt = CHARGE;
          CHARGE:    phase_nxt = DISCHARGE;
          default:   phase_nxt = DISCHARGE;
        endcase
      end else begin
        phase_nxt = phase;
      end
    end else begin
      tcnt_nxt = tcnt;
    end
  end

  // In first-edge mode a channel stops counting once it has seen its node go high.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      inc[n]     = ~sync_b[n] & ((MODE == 0) | ~seen[n]);
      cnt_upd[n] = (inc[n] && (cnt[n] != CNT_MAX)) ? cnt[n] + CNT_W'(1) : cnt[n];
      sum[n]     = acc[n] + ACC_W'(cnt_upd[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt    <= '0;
      seen    <= '0;
      oValid  <= 1'b0;
      oPotVal <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        cnt[n] <= '0;
        acc[n] <= '0;
      end
    end else begin
      oValid <= 1'b0;
      if (clkEn) begin
        if (phase == DISCHARGE) begin
          seen <= '0;
          for (int n = 0; n < NUM_CH; n++) cnt[n] <= '0;
        end else begin
          seen <= last_tick ? '0 : (seen | sync_b);
          for (int n = 0; n < NUM_CH; n++) cnt[n] <= last_tick ? '0 : cnt_upd[n];
        end
        if (last_tick) begin
          wcnt <= (wcnt == WC_MAX) ? '0 : wcnt + WC_W'(1);
          if (wcnt == WC_MAX) begin
            oValid <= 1'b1;
            for (int n = 0; n < NUM_CH; n++) begin
              oPotVal[n*CNT_W +: CNT_W] <= sum[n][AVG_LOG2 +: CNT_W];
              acc[n] <= '0;
            end
          end else begin
            for (int n = 0; n < NUM_CH; n++) acc[n] <= sum[n];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sid_pot_multi.sv
// Bench for sid_pot_multi: three parameterisations share one stimulus; expected results
// come from per-window low-tick patterns counted directly.
module tb_sid_pot_multi;
  localparam int NWIN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clkEn = 1'b0;
  logic [1:0]  iPotIn = 2'b11;
  logic [1:0]  oe0, oe1, oe2;
  logic [15:0] val0, val1, val2;
  logic        v0, v1, v2;

  int          vectors = 0;
  int          miscompares = 0;
  bit          pat [NWIN][2][256];
  logic [15:0] exp0 = 16'd0, exp1 = 16'd0, exp2 = 16'd0;

  always #5 clk = ~clk;

  sid_pot_multi #(.NUM_CH(2), .CNT_W(8), .MODE(0), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .clkEn(clkEn), .iPotIn(iPotIn),
    .oPotOe(oe0), .oPotVal(val0), .oValid(v0));
  sid_pot_multi #(.NUM_CH(2), .CNT_W(8), .MODE(1), .AVG_LOG2(0)) dut1 (
    .clk(clk), .rst(rst), .clkEn(clkEn), .iPotIn(iPotIn),
    .oPotOe(oe1), .oPotVal(val1), .oValid(v1));
  sid_pot_multi #(.NUM_CH(2), .CNT_W(8), .MODE(0), .AVG_LOG2(2)) dut2 (
    .clk(clk), .rst(rst), .clkEn(clkEn), .iPotIn(iPotIn),
    .oPotOe(oe2), .oPotVal(val2), .oValid(v2));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Result of one window: lows counted (mode 0) or lows before first high (mode 1), saturated.
  function automatic int raw(input int w, input int ch, input int mode);
    int lows = 0;
    int first = 256;
    for (int k = 0; k < 256; k++) begin
      if (pat[w][ch][k]) begin
        if (first == 256) first = k;
      end else begin
        lows++;
      end
    end
    raw = (mode == 0) ? lows : first;
    if (raw > 255) raw = 255;
  endfunction

  task automatic set_thresh(input int w, input int ch, input int n);
    for (int k = 0; k < 256; k++) pat[w][ch][k] = (k >= n);
  endtask

  task automatic set_glitch(input int w, input int ch);
    for (int k = 0; k < 256; k++) pat[w][ch][k] = (k == 10) || (k >= 31);
  endtask

  task automatic set_rand(input int w, input int ch);
    int n;
    n = $urandom_range(0, 256);
    for (int k = 0; k < 256; k++) begin
      pat[w][ch][k] = (k >= n);
      if ($urandom_range(0, 15) == 0) pat[w][ch][k] = ~pat[w][ch][k];
    end
  endtask

  // Pad level that the tick on clk edge ed (counted from reset release) must see.
  function automatic logic [1:0] lvl(input int ed, input int d);
    int t, pos, w;
    lvl = 2'b11;
    if (ed % d == 0) begin
      t = ed / d;
      pos = t % 512;
      w = t / 512;
      if (pos >= 256 && w < NWIN) lvl = {pat[w][1][pos-256], pat[w][0][pos-256]};
    end
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      clkEn = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      iPotIn = 2'($urandom);
      @(posedge clk); #1;
      exp0 = 16'd0; exp1 = 16'd0; exp2 = 16'd0;
      chk("rst_valid0", 16'(v0), 16'd0);
      chk("rst_valid1", 16'(v1), 16'd0);
      chk("rst_valid2", 16'(v2), 16'd0);
      chk("rst_oe0", 16'(oe0), 16'h0003);
      chk("rst_oe2", 16'(oe2), 16'h0003);
      chk("rst_val0", val0, 16'd0);
      chk("rst_val1", val1, 16'd0);
      chk("rst_val2", val2, 16'd0);
    end
    rst = 1'b0;
  endtask

  // Runs ticks 0..stop-1 with clkEn high on every d-th clk, checking every edge.
  task automatic run_seg(input int d, input int stop);
    for (int e = 0; e < d * stop; e++) begin
      int t, w, td, a0, a1;
      bit fin;
      logic [1:0] oe_exp;
      clkEn = (e % d == 0);
      iPotIn = lvl(e + 2, d);
      @(posedge clk); #1;
      t = e / d;
      w = t / 512;
      td = t + 1;
      fin = (e % d == 0) && (t % 512 == 511);
      oe_exp = ((td % 512) < 256) ? 2'b11 : 2'b00;
      if (fin) begin
        exp0 = 16'(raw(w, 1, 0) * 256 + raw(w, 0, 0));
        exp1 = 16'(raw(w, 1, 1) * 256 + raw(w, 0, 1));
        if (w % 4 == 3) begin
          a0 = (raw(w-3, 0, 0) + raw(w-2, 0, 0) + raw(w-1, 0, 0) + raw(w, 0, 0)) / 4;
          a1 = (raw(w-3, 1, 0) + raw(w-2, 1, 0) + raw(w-1, 1, 0) + raw(w, 1, 0)) / 4;
          exp2 = 16'(a1 * 256 + a0);
        end
      end
      chk("valid0", 16'(v0), 16'(fin));
      chk("valid1", 16'(v1), 16'(fin));
      chk("valid2", 16'(v2), 16'(fin && (w % 4 == 3)));
      chk("oe0", 16'(oe0), 16'(oe_exp));
      chk("oe1", 16'(oe1), 16'(oe_exp));
      chk("oe2", 16'(oe2), 16'(oe_exp));
      chk("val0", val0, exp0);
      chk("val1", val1, exp1);
      chk("val2", val2, exp2);
    end
  endtask

  initial begin
    do_reset(3);

    // Continuous clkEn: static levels, threshold, glitch, random, then an averaging run on ch0.
    set_thresh(0, 0, 0);   set_thresh(0, 1, 256);
    set_thresh(1, 0, 100); set_thresh(1, 1, 100);
    set_glitch(2, 0);      set_glitch(2, 1);
    set_rand(3, 0);        set_rand(3, 1);
    for (int i = 0; i < 4; i++) begin
      set_thresh(4 + i, 0, 10 + i);
      set_rand(4 + i, 1);
    end
    run_seg(1, NWIN * 512);
    do_reset(2);

    // 1-in-4 clkEn: result period stretches to 2048 clk.
    set_thresh(0, 0, 100); set_thresh(0, 1, 100);
    set_thresh(1, 0, 100); set_rand(1, 1);
    run_seg(4, 1024);
    do_reset(2);

    // Reset at charge tick 50 of the second window discards that window.
    set_rand(0, 0);        set_rand(0, 1);
    set_thresh(1, 0, 100); set_thresh(1, 1, 100);
    run_seg(4, 512 + 256 + 50);
    do_reset(2);

    // Reset on the final charge tick: no result for that window.
    set_rand(0, 0); set_rand(0, 1);
    set_rand(1, 0); set_rand(1, 1);
    run_seg(1, 1023);
    do_reset(2);

    // Full windows after reset produce results again.
    set_thresh(0, 0, 100); set_thresh(0, 1, 100);
    set_rand(1, 0);        set_rand(1, 1);
    run_seg(1, 1024);
    do_reset(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
